// File: rtl/display_selector_pkg.sv
// ---------------------------------------------------------------------------
// display_selector_pkg
//   Shared definitions for the clock display path: the display mode
//   encoding driven on Modo, the default PS/2 scan codes that control the
//   selector, and small helpers used by the mode FSM. The keyboard decoder
//   and the clock display top import this same package so scan codes and
//   mode values are defined in exactly one place.
// ---------------------------------------------------------------------------
package display_selector_pkg;

    // Encoding of the Modo output.
    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_HOLD   = 2'b10
    } mode_e;

    // Default PS/2 set-2 make codes.
    localparam logic [7:0] KEY_NEXT_DEF = 8'h74;  // right arrow
    localparam logic [7:0] KEY_PREV_DEF = 8'h6B;  // left arrow
    localparam logic [7:0] KEY_AUTO_DEF = 8'h6C;  // home
    localparam logic [7:0] KEY_HOLD_DEF = 8'h29;  // space

    // Channel stepping and auto-cycling are only permitted outside HOLD.
    function automatic logic mode_is_live(input mode_e m);
        return m != MODE_HOLD;
    endfunction

endpackage : display_selector_pkg

// File: rtl/dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
//   Counts clk cycles while enabled and produces a single-cycle tick when
//   the count reaches DWELL-1; the count wraps to zero on that same edge,
//   so consecutive ticks are exactly DWELL cycles apart. When disabled the
//   count is held. A clear request always wins: it zeroes the count and
//   suppresses a tick that would otherwise fire in the same cycle.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   enable  in   count this cycle
//   clear   in   zero the count (priority over enable and tick)
//   tick    out  high in the cycle the count is at DWELL-1 and enabled
// ---------------------------------------------------------------------------
module dwell_timer #(
    parameter int DWELL = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_MAX);

    // tick is combinational so the consumer steps on the same edge the
    // count wraps, keeping the channel period exactly DWELL cycles.
    assign tick = enable && !clear && at_max;

    // NOTE: every signal written in always_comb gets a default on the first
    // line so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : dwell_timer

// File: rtl/display_selector.sv
// ---------------------------------------------------------------------------
// display_selector
//   Chooses which of N_CH display channels (time, date, timer, ...) drives
//   the three display fields. A PS/2 key FSM selects MANUAL stepping, AUTO
//   cycling (one channel every DWELL cycles) or HOLD, which freezes both the
//   channel index and the displayed fields until HOLD is pressed again and
//   the previous mode is restored.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   Estado       in   8-bit scan code, qualified by Tecla_valid
//   Tecla_valid  in   one-cycle strobe marking Estado valid
//   Campo_1      in   N_CH packed field-1 values, channel k at [k*W1 +: W1]
//   Campo_2      in   N_CH packed field-2 values, channel k at [k*W2 +: W2]
//   Campo_3      in   N_CH packed field-3 values, channel k at [k*W3 +: W3]
//   Salida_1..3  out  registered fields of the displayed channel
//   Canal        out  index of the displayed channel
//   Modo         out  current mode (00 MANUAL, 01 AUTO, 10 HOLD)
//   Cambio       out  one-cycle pulse in the first cycle of a new Canal
// ---------------------------------------------------------------------------
module display_selector
    import display_selector_pkg::*;
#(
    parameter int         N_CH     = 3,
    parameter int         W1       = 7,
    parameter int         W2       = 6,
    parameter int         W3       = 5,
    parameter int         DWELL    = 100_000_000,
    parameter logic [7:0] KEY_NEXT = KEY_NEXT_DEF,
    parameter logic [7:0] KEY_PREV = KEY_PREV_DEF,
    parameter logic [7:0] KEY_AUTO = KEY_AUTO_DEF,
    parameter logic [7:0] KEY_HOLD = KEY_HOLD_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 Estado,
    input  logic                       Tecla_valid,
    input  logic [N_CH*W1-1:0]         Campo_1,
    input  logic [N_CH*W2-1:0]         Campo_2,
    input  logic [N_CH*W3-1:0]         Campo_3,
    output logic [W1-1:0]              Salida_1,
    output logic [W2-1:0]              Salida_2,
    output logic [W3-1:0]              Salida_3,
    output logic [$clog2(N_CH)-1:0]    Canal,
    output logic [1:0]                 Modo,
    output logic                       Cambio
);

    localparam int CW = $clog2(N_CH);
    localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);

    // Registered state
    mode_e          mode_q,   mode_d;
    mode_e          saved_q,  saved_d;   // mode to return to when HOLD ends
    logic [CW-1:0]  canal_q,  canal_d;
    logic [W1-1:0]  sal1_q,   sal1_d;
    logic [W2-1:0]  sal2_q,   sal2_d;
    logic [W3-1:0]  sal3_q,   sal3_d;
    logic           cambio_q, cambio_d;

    // Key decode and timer handshake
    logic key_step;     // a NEXT/PREV key was accepted this cycle
    logic enter_auto;   // MANUAL -> AUTO transition this cycle
    logic dwell_tick;
    int unsigned sel;

    // -----------------------------------------------------------------------
    // Dwell timer: runs only in AUTO. A manual step or entry into AUTO
    // restarts the period; the clear also masks a coincident tick, which is
    // how a key step wins over dwell expiry.
    // -----------------------------------------------------------------------
    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (mode_q == MODE_AUTO),
        .clear  (key_step || enter_auto),
        .tick   (dwell_tick)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        mode_d     = mode_q;
        saved_d    = saved_q;
        canal_d    = canal_q;
        key_step   = 1'b0;
        enter_auto = 1'b0;
        sel        = int'(canal_q);

        if (Tecla_valid) begin
            case (Estado)
                KEY_NEXT: begin
                    if (mode_is_live(mode_q)) begin
                        key_step = 1'b1;
                        canal_d  = (canal_q == CH_LAST) ? '0 : canal_q + CW'(1);
                    end
                end
                KEY_PREV: begin
                    if (mode_is_live(mode_q)) begin
                        key_step = 1'b1;
                        canal_d  = (canal_q == '0) ? CH_LAST : canal_q - CW'(1);
                    end
                end
                KEY_AUTO: begin
                    if (mode_q == MODE_MANUAL) begin
                        mode_d     = MODE_AUTO;
                        enter_auto = 1'b1;
                    end else if (mode_q == MODE_AUTO) begin
                        mode_d = MODE_MANUAL;
                    end
                end
                KEY_HOLD: begin
                    if (mode_q == MODE_HOLD) begin
                        mode_d = saved_q;
                    end else begin
                        saved_d = mode_q;
                        mode_d  = MODE_HOLD;
                    end
                end
                default: ;
            endcase
        end

        // The timer already suppresses the tick during a key step, so an
        // auto advance never stacks on top of a manual one.
        if (dwell_tick) begin
            canal_d = (canal_q == CH_LAST) ? '0 : canal_q + CW'(1);
        end

        // Fields follow the channel registered last cycle, giving the
        // one-cycle lag between a Canal change and the new Salida values.
        // In HOLD the inputs are not sampled at all.
        if (mode_is_live(mode_q)) begin
            sal1_d = Campo_1[sel*W1 +: W1];
            sal2_d = Campo_2[sel*W2 +: W2];
            sal3_d = Campo_3[sel*W3 +: W3];
        end else begin
            sal1_d = sal1_q;
            sal2_d = sal2_q;
            sal3_d = sal3_q;
        end

        cambio_d = (canal_d != canal_q);
    end

    // -----------------------------------------------------------------------
    // Mode FSM and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= MODE_MANUAL;
            saved_q  <= MODE_MANUAL;
            canal_q  <= '0;
            // NOTE: the field registers are reset too, because the display
            // must show zeros rather than stale data right after reset.
            sal1_q   <= '0;
            sal2_q   <= '0;
            sal3_q   <= '0;
            cambio_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            saved_q  <= saved_d;
            canal_q  <= canal_d;
            sal1_q   <= sal1_d;
            sal2_q   <= sal2_d;
            sal3_q   <= sal3_d;
            cambio_q <= cambio_d;
        end
    end

    assign Salida_1 = sal1_q;
    assign Salida_2 = sal2_q;
    assign Salida_3 = sal3_q;
    assign Canal    = canal_q;
    assign Modo     = mode_q;
    assign Cambio   = cambio_q;

endmodule : display_selector

// File: tb/tb_display_selector.sv
// ---------------------------------------------------------------------------
// tb_display_selector
//   Directed scenarios followed by randomized key/field traffic. Every cycle
//   a behavioural model of the selector predicts all outputs; the DUT is
//   compared against it half a clock after each rising edge.
// ---------------------------------------------------------------------------
module tb_display_selector;

    localparam int N_CH  = 3;
    localparam int W1    = 7;
    localparam int W2    = 6;
    localparam int W3    = 5;
    localparam int DWELL = 4;
    localparam int CW    = $clog2(N_CH);

    localparam logic [7:0] K_NEXT = 8'h74;
    localparam logic [7:0] K_PREV = 8'h6B;
    localparam logic [7:0] K_AUTO = 8'h6C;
    localparam logic [7:0] K_HOLD = 8'h29;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [7:0]           estado = '0;
    logic                 tecla_valid = 1'b0;
    logic [N_CH*W1-1:0]   campo_1 = '0;
    logic [N_CH*W2-1:0]   campo_2 = '0;
    logic [N_CH*W3-1:0]   campo_3 = '0;
    logic [W1-1:0]        salida_1;
    logic [W2-1:0]        salida_2;
    logic [W3-1:0]        salida_3;
    logic [CW-1:0]        canal;
    logic [1:0]           modo;
    logic                 cambio;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (mode: 0 manual, 1 auto, 2 hold)
    int m_mode, m_saved, m_canal, m_cnt, m_cambio;
    int m_s1, m_s2, m_s3;

    always #5 clk = ~clk;

    display_selector #(
        .N_CH  (N_CH),
        .W1    (W1),
        .W2    (W2),
        .W3    (W3),
        .DWELL (DWELL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Estado      (estado),
        .Tecla_valid (tecla_valid),
        .Campo_1     (campo_1),
        .Campo_2     (campo_2),
        .Campo_3     (campo_3),
        .Salida_1    (salida_1),
        .Salida_2    (salida_2),
        .Salida_3    (salida_3),
        .Canal       (canal),
        .Modo        (modo),
        .Cambio      (cambio)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model of one rising edge, using the inputs currently applied.
    task automatic model_edge(input logic rst, input logic v, input logic [7:0] code);
        int nc, nm, ncnt;
        bit step;
        if (rst) begin
            m_mode = 0; m_saved = 0; m_canal = 0; m_cnt = 0; m_cambio = 0;
            m_s1 = 0; m_s2 = 0; m_s3 = 0;
            return;
        end
        if (m_mode != 2) begin
            m_s1 = int'(campo_1[m_canal*W1 +: W1]);
            m_s2 = int'(campo_2[m_canal*W2 +: W2]);
            m_s3 = int'(campo_3[m_canal*W3 +: W3]);
        end
        nc = m_canal; nm = m_mode; ncnt = m_cnt; step = 0;
        if (v) begin
            if (code == K_NEXT && m_mode != 2) begin
                nc = (m_canal + 1) % N_CH; step = 1;
            end else if (code == K_PREV && m_mode != 2) begin
                nc = (m_canal + N_CH - 1) % N_CH; step = 1;
            end else if (code == K_AUTO) begin
                if (m_mode == 0) begin nm = 1; ncnt = 0; end
                else if (m_mode == 1) nm = 0;
            end else if (code == K_HOLD) begin
                if (m_mode != 2) begin m_saved = m_mode; nm = 2; end
                else nm = m_saved;
            end
        end
        if (step) ncnt = 0;
        else if (m_mode == 1) begin
            if (m_cnt == DWELL - 1) begin
                ncnt = 0;
                nc = (m_canal + 1) % N_CH;
            end else begin
                ncnt = m_cnt + 1;
            end
        end
        m_cambio = (nc != m_canal) ? 1 : 0;
        m_canal = nc; m_mode = nm; m_cnt = ncnt;
    endtask

    // Apply inputs (called at a falling edge), let one rising edge pass,
    // then compare every output at the next falling edge.
    task automatic cycle(input logic rst, input logic v, input logic [7:0] code);
        reset = rst; tecla_valid = v; estado = code;
        model_edge(rst, v, code);
        @(negedge clk);
        check("salida_1", 32'(salida_1), 32'(m_s1));
        check("salida_2", 32'(salida_2), 32'(m_s2));
        check("salida_3", 32'(salida_3), 32'(m_s3));
        check("canal",    32'(canal),    32'(m_canal));
        check("modo",     32'(modo),     32'(m_mode));
        check("cambio",   32'(cambio),   32'(m_cambio));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic randomize_fields();
        for (int k = 0; k < N_CH; k++) begin
            campo_1[k*W1 +: W1] = W1'($urandom);
            campo_2[k*W2 +: W2] = W2'($urandom);
            campo_3[k*W3 +: W3] = W3'($urandom);
        end
    endtask

    initial begin
        int found, gap;
        int prev_canal;
        logic [7:0] codes [5];

        @(negedge clk);

        // Reset state
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, K_NEXT);

        // Channel fields 10/20/30 on field 1
        campo_1 = {7'd30, 7'd20, 7'd10};
        campo_2 = {6'd33, 6'd22, 6'd11};
        campo_3 = {5'd3, 5'd2, 5'd1};
        cycle(1'b0, 1'b0, 8'h00);
        check("req035_salida_1", 32'(salida_1), 32'd10);
        check("req035_canal",    32'(canal),    32'd0);
        check("req035_modo",     32'(modo),     32'd0);
        check("req035_cambio",   32'(cambio),   32'd0);

        // Step up to channel 2, wrap forward to 0, wrap back to 2
        cycle(1'b0, 1'b1, K_NEXT);
        cycle(1'b0, 1'b1, K_NEXT);
        idle();
        check("req036_salida_1_ch2", 32'(salida_1), 32'd30);
        cycle(1'b0, 1'b1, K_NEXT);
        check("req036_wrap_canal",  32'(canal),  32'd0);
        check("req036_wrap_cambio", 32'(cambio), 32'd1);
        idle();
        check("req036_cambio_once", 32'(cambio), 32'd0);
        cycle(1'b0, 1'b1, K_PREV);
        check("req036_prev_canal",  32'(canal),  32'd2);

        // Unrecognised code and a key code without the strobe
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b0, 1'b0, K_NEXT);
        check("req022_no_effect", 32'(canal), 32'd2);

        // AUTO cycling, one channel every DWELL cycles
        cycle(1'b0, 1'b1, K_AUTO);
        check("req037_modo", 32'(modo), 32'd1);
        prev_canal = int'(canal);
        gap = 0;
        for (int i = 1; i <= 3 * DWELL; i++) begin
            idle();
            if (int'(canal) != prev_canal) begin
                if (gap == 0) check("req037_first_gap", 32'(i), 32'(DWELL));
                gap = i;
                prev_canal = int'(canal);
            end
        end
        check("req037_final_gap", 32'(gap), 32'(3 * DWELL));
        check("req037_canal", 32'(canal), 32'd2);

        // HOLD on channel 1
        found = 0;
        for (int i = 0; i < 4 * DWELL; i++) begin
            if (m_canal == 1 && m_cnt == 1) begin found = 1; break; end
            idle();
        end
        check("req038_reach_ch1", 32'(found), 32'd1);
        cycle(1'b0, 1'b1, K_HOLD);
        check("req038_modo_hold", 32'(modo), 32'd2);
        for (int i = 0; i < 20; i++) begin
            randomize_fields();
            cycle(1'b0, (i % 3) == 0, (i % 2) ? K_NEXT : K_AUTO);
        end
        check("req038_canal_frozen",    32'(canal),    32'd1);
        check("req038_salida_1_frozen", 32'(salida_1), 32'd20);
        check("req038_salida_3_frozen", 32'(salida_3), 32'd2);
        cycle(1'b0, 1'b1, K_HOLD);
        check("req038_modo_resume", 32'(modo), 32'd1);
        // Counter held at 2 across HOLD, so the step lands after DWELL-2 cycles
        prev_canal = int'(canal);
        gap = 0;
        for (int i = 1; i <= DWELL; i++) begin
            idle();
            if (gap == 0 && int'(canal) != prev_canal) gap = i;
        end
        check("req038_resume_gap", 32'(gap), 32'(DWELL - 2));

        // NEXT coincident with dwell expiry
        found = 0;
        for (int i = 0; i < 2 * DWELL; i++) begin
            if (m_cnt == DWELL - 1) begin found = 1; break; end
            idle();
        end
        check("req039_reach_expiry", 32'(found), 32'd1);
        prev_canal = int'(canal);
        cycle(1'b0, 1'b1, K_NEXT);
        check("req039_single_step", 32'(canal), 32'((prev_canal + 1) % N_CH));
        prev_canal = int'(canal);
        gap = 0;
        for (int i = 1; i <= 2 * DWELL; i++) begin
            idle();
            if (gap == 0 && int'(canal) != prev_canal) gap = i;
        end
        check("req039_next_gap", 32'(gap), 32'(DWELL));

        // Reset mid-HOLD with a key strobe present
        cycle(1'b0, 1'b1, K_HOLD);
        idle();
        cycle(1'b1, 1'b1, K_HOLD);
        check("req040_canal",    32'(canal),    32'd0);
        check("req040_modo",     32'(modo),     32'd0);
        check("req040_salida_1", 32'(salida_1), 32'd0);
        check("req040_salida_2", 32'(salida_2), 32'd0);
        check("req040_cambio",   32'(cambio),   32'd0);

        // Randomized traffic
        codes[0] = K_NEXT; codes[1] = K_PREV; codes[2] = K_AUTO; codes[3] = K_HOLD;
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic [7:0] c;
            logic r;
            codes[4] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) randomize_fields();
            v = ($urandom_range(0, 9) < 3);
            c = codes[$urandom_range(0, 4)];
            r = ($urandom_range(0, 199) == 0);
            cycle(r, v, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_display_selector
